// File: rtl/mux2to1_arbiter.sv
// Two-requester round-robin arbiter driving a registered-select 2:1 mux.
// Define MUX_ARB_TIMEOUT_EN to cap each grant at MAX_HOLD cycles while the other side waits.
module mux2to1_arbiter #(
  parameter int unsigned W        = 1,
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic         REQ0,
  input  logic         REQ1,
  input  logic [W-1:0] X,
  input  logic [W-1:0] Y,
  output logic         GNT0,
  output logic         GNT1,
  output logic         S,
  output logic [W-1:0] Q,
  output logic         VALID
);

  // One-hot grant encoding lets GNT0/GNT1 come straight off state flops.
  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    GRANT0 = 2'b01,
    GRANT1 = 2'b10
  } state_t;

  state_t state, state_nxt;
  logic   last;
  logic   expired;

  if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_hold
    $error("mux2to1_arbiter: MAX_HOLD must be in 2..255");
  end

`ifdef MUX_ARB_TIMEOUT_EN
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
  logic [7:0] hold_cnt;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      hold_cnt <= '0;
    end else if (state_nxt != state || state_nxt == IDLE) begin
      hold_cnt <= '0;
    end else if (hold_cnt != HOLD_LAST) begin
      hold_cnt <= hold_cnt + 8'd1;
    end
  end

  assign expired = (hold_cnt == HOLD_LAST);
`else
  assign expired = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (REQ0 && REQ1) state_nxt = last ? GRANT0 : GRANT1;
        else if (REQ0)    state_nxt = GRANT0;
        else if (REQ1)    state_nxt = GRANT1;
      end
      GRANT0: begin
        if (REQ0 && !(expired && REQ1)) state_nxt = GRANT0;
        else if (REQ1)                  state_nxt = GRANT1;
        else                            state_nxt = IDLE;
      end
      GRANT1: begin
        if (REQ1 && !(expired && REQ0)) state_nxt = GRANT1;
        else if (REQ0)                  state_nxt = GRANT0;
        else                            state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // S and last only move when a grant is (re)taken, so S holds through IDLE.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= IDLE;
      last  <= 1'b1;
      S     <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state_nxt == GRANT0) begin
        last <= 1'b0;
        S    <= 1'b0;
      end else if (state_nxt == GRANT1) begin
        last <= 1'b1;
        S    <= 1'b1;
      end
    end
  end

  assign GNT0  = state[0];
  assign GNT1  = state[1];
  assign VALID = GNT0 | GNT1;
  assign Q     = (~{W{S}} & X) | ({W{S}} & Y);

endmodule

// File: doc/mux2to1_arbiter.md
MUX2TO1_ARBITER -- requirements
Module: mux2to1_arbiter

Interface
REQ-001 SHALL have parameter W, default 1: data width of each input and of Q.
REQ-002 SHALL have parameter MAX_HOLD, default 4: maximum consecutive grant cycles when `MUX_ARB_TIMEOUT_EN` is defined; legal range 2..255.
REQ-003 SHALL have port CLK  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port RST_N  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port REQ0  input  1  requester 0 wants the shared output.
REQ-006 SHALL have port REQ1  input  1  requester 1 wants the shared output.
REQ-007 SHALL have port X  input  W  requester 0 data.
REQ-008 SHALL have port Y  input  W  requester 1 data.
REQ-009 SHALL have port GNT0  output  1  requester 0 owns the output, registered.
REQ-010 SHALL have port GNT1  output  1  requester 1 owns the output, registered.
REQ-011 SHALL have port S  output  1  mux select, registered; 0 selects X, 1 selects Y.
REQ-012 SHALL have port Q  output  W  combinational (~S & X) | (S & Y), bitwise across W.
REQ-013 SHALL have port VALID  output  1  GNT0 | GNT1.

Function
REQ-014 SHALL implement FSM states IDLE, GRANT0, GRANT1; GNT0=1 only in GRANT0, GNT1=1 only in GRANT1; never both.
REQ-015 SHALL register grant: request seen at edge n -> GNTx and S valid after edge n; latency 1 cycle.
REQ-016 SHALL keep a LAST pointer (last granted requester), updated on every entry to GRANT0/GRANT1.
REQ-017 IDLE: REQ0 only -> GRANT0; REQ1 only -> GRANT1; both -> grant requester != LAST; none -> stay IDLE.
REQ-018 GRANTk with REQk=1 (and no timeout rotation) -> stay GRANTk.
REQ-019 GRANTk with REQk=0 and other request=1 -> go directly to other grant state, no IDLE bubble.
REQ-020 GRANTk with REQk=0 and other request=0 -> IDLE.
REQ-021 S SHALL be 0 in GRANT0, 1 in GRANT1, and hold its previous value in IDLE.
REQ-022 Simultaneous REQ0 and REQ1 rising in the same cycle SHALL resolve per LAST, giving round-robin fairness.
REQ-023 Requests are level-sensitive; a request deasserted before being granted SHALL be dropped silently.

Reset
REQ-024 RST_N=0 SHALL immediately, independent of CLK, force state IDLE, GNT0=0, GNT1=0, S=0, LAST=1 (requester 0 wins first tie), hold counter=0.
REQ-025 Reset asserted mid-grant SHALL drop grant asynchronously; first possible grant is at the first rising edge after RST_N deasserts.

Configuration
REQ-026 Macro MUX_ARB_TIMEOUT_EN defined: an 8-bit hold counter SHALL clear on entry to a grant state, increment each cycle in the grant state, and saturate at MAX_HOLD-1.
REQ-027 With MUX_ARB_TIMEOUT_EN, when the counter reaches MAX_HOLD-1 in GRANTk and the other request=1, the next state SHALL be the other grant state even if REQk=1, giving a grant of exactly MAX_HOLD cycles.
REQ-028 With MUX_ARB_TIMEOUT_EN, when the counter saturates and the other request=0, the grant SHALL continue.
REQ-029 Macro MUX_ARB_TIMEOUT_EN undefined: no counter logic; the grant SHALL persist while REQk=1, and MAX_HOLD is ignored.

Verification
REQ-030 Reset: RST_N=0 with REQ0=REQ1=1 -> GNT0=GNT1=0, S=0, VALID=0; release -> after 1 edge GNT0=1, S=0, Q=X.
REQ-031 Alternation: REQ0=REQ1=1 pulsed 1 cycle each round, 4 rounds -> grants 0,1,0,1.
REQ-032 Handover: GRANT0 held, REQ0 drops while REQ1=1 -> next cycle GNT1=1, S=1, Q=Y; VALID stays 1 throughout.
REQ-033 Timeout (macro on, MAX_HOLD=4): REQ0=REQ1=1 held -> GNT0 for exactly 4 cycles, then GNT1 for 4 cycles, repeating.
REQ-034 No timeout (macro off): REQ0=REQ1=1 held 20 cycles -> GNT0=1 for all 20 cycles; REQ0 drops -> GNT1=1 next cycle.
REQ-035 Mid-grant reset: GRANT1 active, RST_N low between edges -> GNT1=0 and S=0 before the next edge.
